// File: rtl/alu_pkg.sv
// Shared opcode and FSM definitions for the registered ALU.
// Imported by seq_alu and mul_iter.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier engine, one partial product per step.
// prod presents the accumulator including the current step's add.
module mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] prod,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_nxt;

  // Accumulator after conditionally adding the current multiplicand
  always_comb begin
    acc_nxt = acc;
    if (mplier[0]) acc_nxt = acc + mcand;
  end

  assign prod = acc_nxt;
  assign last = (cnt == CW'(WIDTH - 1));

  // Load operands on acceptance, then shift one bit per step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered EX-stage ALU: single-cycle ops plus optional iterative mul.
// Outputs change only on completion edges; zero tracks the result reg.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1,
  parameter int SHW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   shamt;
  logic             is_mul;
  logic             accept;
  logic [WIDTH-1:0] mul_prod;
  logic             mul_last;

  assign sum    = a + b;
  assign diff   = a - b;
  assign shamt  = b[SHW-1:0];
  assign is_mul = (MUL_EN != 0) && (alu_control == OP_MUL);
  assign accept = start && (state == ST_IDLE);
  assign zero   = (result == '0);

  // Single-cycle result and add/sub signed overflow
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alu_control)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) &&
                  (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) &&
                  (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_OR:   alu_res = a | b;
      OP_AND:  alu_res = a & b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                          ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: alu_res = '0;
    endcase
  end

  generate
    if (MUL_EN != 0) begin : g_mul
      mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .reset (reset),
        .load  (accept && is_mul),
        .step  (state == ST_MUL),
        .a     (a),
        .b     (b),
        .prod  (mul_prod),
        .last  (mul_last)
      );
    end else begin : g_nomul
      assign mul_prod = '0;
      assign mul_last = 1'b0;
    end
  endgenerate

  // Control FSM with registered result, flags and handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      result   <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (is_mul) begin
              state <= ST_MUL;
              busy  <= 1'b1;
            end else begin
              result   <= alu_res;
              overflow <= alu_ovf;
              done     <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (mul_last) begin
            result   <= mul_prod;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed plus randomized bench for seq_alu (WIDTH=32, MUL_EN=1).
// Expected values come from a plain-arithmetic reference model.
module tb_seq_alu;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [3:0]    alu_control = '0;
  logic [W-1:0]  result;
  logic          zero;
  logic          overflow;
  logic          busy;
  logic          done;

  int total = 0;
  int passed = 0;

  seq_alu #(.WIDTH(W), .MUL_EN(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .a           (a),
    .b           (b),
    .alu_control (alu_control),
    .result      (result),
    .zero        (zero),
    .overflow    (overflow),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: returns {overflow, result}
  function automatic logic [W:0] model(input logic [3:0] op,
                                       input logic [W-1:0] x,
                                       input logic [W-1:0] y);
    longint sx, sy, s;
    logic [63:0] p;
    int sh;
    logic [W-1:0] r;
    logic o;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = int'(y % W);
    r = '0;
    o = 1'b0;
    case (op)
      4'd0: begin
        s = sx + sy; r = x + y;
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd1: r = x | y;
      4'd2: r = x & y;
      4'd3: r = x << sh;
      4'd4: begin
        s = sx - sy; r = x - y;
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd5: r = x ^ y;
      4'd6: r = x >> sh;
      4'd7: begin s = sx >>> sh; r = s[W-1:0]; end
      4'd8: r = (sx < sy) ? 1 : 0;
      4'd9: r = (x < y) ? 1 : 0;
      4'd10: begin p = {32'b0, x} * {32'b0, y}; r = p[W-1:0]; end
      default: r = '0;
    endcase
    return {o, r};
  endfunction

  // Drive a request, let it be accepted, then scramble the inputs
  task automatic issue(input logic [3:0] op, input logic [W-1:0] x,
                       input logic [W-1:0] y);
    alu_control = op;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    alu_control = 4'($urandom);
  endtask

  task automatic run_single(input string tag, input logic [3:0] op,
                            input logic [W-1:0] x,
                            input logic [W-1:0] y);
    logic [W:0] e;
    e = model(op, x, y);
    issue(op, x, y);
    check({tag, ".done"}, 64'(done), 64'd1);
    check({tag, ".busy"}, 64'(busy), 64'd0);
    check({tag, ".res"}, 64'(result), 64'(e[W-1:0]));
    check({tag, ".ovf"}, 64'(overflow), 64'(e[W]));
    check({tag, ".zero"}, 64'(zero), 64'(e[W-1:0] == '0));
  endtask

  // Runs a multiply and returns in its done cycle (#1 after edge)
  task automatic run_mul(input string tag, input logic [W-1:0] x,
                         input logic [W-1:0] y, input bit poke);
    logic [W:0] e;
    logic [W-1:0] held;
    int n;
    int bcnt;
    e = model(4'd10, x, y);
    held = result;
    issue(4'd10, x, y);
    n = 0;
    bcnt = busy ? 1 : 0;
    while (!done && n < W + 10) begin
      if (poke && n == 5) begin
        start = 1'b1;
        alu_control = 4'd0;
      end
      if (poke && n == 6) begin
        check({tag, ".held"}, 64'(result), 64'(held));
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
      if (busy) bcnt++;
    end
    check({tag, ".lat"}, 64'(n + 1), 64'(W + 1));
    check({tag, ".busycyc"}, 64'(bcnt), 64'(W));
    check({tag, ".res"}, 64'(result), 64'(e[W-1:0]));
    check({tag, ".ovf"}, 64'(overflow), 64'd0);
    check({tag, ".zero"}, 64'(zero), 64'(e[W-1:0] == '0));
  endtask

  initial begin
    bit saw;
    logic [3:0] op;
    #1;
    check("rst.res", 64'(result), 64'd0);
    check("rst.zero", 64'(zero), 64'd1);
    check("rst.ovf", 64'(overflow), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_single("add_ovf", 4'd0, 32'h7FFFFFFF, 32'h1);
    run_single("sub_eq", 4'd4, 32'd5, 32'd5);
    run_single("slt", 4'd8, 32'hFFFFFFFF, 32'h1);
    run_single("sltu", 4'd9, 32'hFFFFFFFF, 32'h1);
    run_single("sra", 4'd7, 32'h80000000, 32'h00000124);
    run_single("srl", 4'd6, 32'h80000000, 32'h00000124);
    run_single("sub_ovf", 4'd4, 32'h80000000, 32'h1);
    run_single("sll", 4'd3, 32'h00000001, 32'hFFFFFFFF);

    run_mul("mul", 32'h00010003, 32'd7, 1'b1);
    check("mul.val", 64'(result), 64'h00070015);

    // Back-to-back: add accepted in the mul done cycle
    run_single("b2b_add", 4'd0, 32'd10, 32'd20);

    // Reset mid-multiply
    issue(4'd10, 32'h12345678, 32'h9ABCDEF1);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mrst.res", 64'(result), 64'd0);
    check("mrst.zero", 64'(zero), 64'd1);
    check("mrst.busy", 64'(busy), 64'd0);
    check("mrst.done", 64'(done), 64'd0);
    check("mrst.ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    saw = 1'b0;
    repeat (W + 5) begin
      @(posedge clk);
      #1;
      if (done) saw = 1'b1;
    end
    check("mrst.nodone", 64'(saw), 64'd0);
    run_single("post_add", 4'd0, 32'd2, 32'd3);
    run_single("op_f", 4'hF, 32'h1234, 32'h5678);

    // Randomized sweep over all opcodes
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'd10)
        run_mul("rnd_mul", $urandom, $urandom, 1'b0);
      else
        run_single("rnd", op, $urandom, $urandom);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
